seq_alu: RTL
============

Name: seq_alu

Overview:
Multi-cycle execute unit that sits directly downstream of the ALU input-assignment stage. It consumes the two selected operands, inp1 and inp2, plus a decoded ALU op. It returns a registered result and condition flags (carry, zero, sign, overflow) to writeback and branch logic. Logical and arithmetic ops complete in one cycle; shifts iterate one bit per cycle, so the unit uses a start/busy/done handshake.

Parameters:
WIDTH, 32, datapath width in bits.
SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
clk  input  1  clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request to begin an op; accepted only when ready=1.
alu_op  input  4  op select (encodings below).
inp1  input  WIDTH  operand A (rs).
inp2  input  WIDTH  operand B (rt, zero-extended shamt, or sign-extended immediate).
ready  output  1  unit can accept start this cycle.
busy  output  1  op in flight.
done  output  1  one-cycle pulse; result and flags valid.
result  output  WIDTH  registered result; held until the next accepted start.
flag_c  output  1  carry / last bit shifted out.
flag_z  output  1  result == 0.
flag_s  output  1  result[WIDTH-1].
flag_v  output  1  signed overflow (ADD only).
illegal  output  1  unused alu_op was accepted; pulses with done.

Behaviour:
- Op encodings:
  - ADD=0: result = A+B.
  - COMP=1: result = -B, two's complement.
  - AND=2.
  - XOR=3.
  - SHLL=4.
  - SHRL=5.
  - SHRA=6.
  - 7..15: illegal; result=0 with illegal=1.
- Shift ops use n = B[SHAMT_W-1:0]; upper bits of B are ignored.
- Reset: state=IDLE; result, flags, done, illegal, busy = 0; ready=1. Reset mid-shift aborts the op with no done pulse.
- FSM states are IDLE, SHIFT, DONE.
  - ready=1 in IDLE and DONE. busy=1 in SHIFT only. done=1 exactly in DONE.
  - A start accepted in DONE chains back-to-back; done then drops for at least one cycle unless the new op is single-cycle.
- Accept (start & ready):
  - Non-shift op: compute on the accept edge and go to DONE; done is high in the cycle after accept (latency 1).
  - Shift with n=0: result=A, flag_c=0, go to DONE (latency 1).
  - Shift with n>0: load acc=A and cnt=n, go to SHIFT.
- SHIFT state: on each edge, shift acc by one bit and set flag_c to the bit shifted out, then decrement cnt.
  - SHLL fills with 0; SHRL fills with 0; SHRA fills with the sign bit.
  - When cnt reaches 0, go to DONE with result=acc.
  - done rises n+1 cycles after accept.
- start while busy is ignored: no queueing, operands are not sampled.
- Once accepted, the unit does not depend on inp1, inp2 or alu_op staying stable.
- DONE with no new start: go to IDLE next cycle; result and flags are held.
- Flag rules:
  - ADD: flag_c = carry out of the WIDTH-bit sum; flag_v = (A[msb]==B[msb]) & (R[msb]!=A[msb]).
  - COMP, AND, XOR: flag_c=0 and flag_v=0.
  - Shifts: flag_v=0.
  - flag_z and flag_s are always derived from the final result.
- Flags update only when done asserts; intermediate shift values are never visible on result.

Optional Feature:
Macro SEQ_ALU_BARREL_EN.
- Defined: shifts are computed combinationally by a barrel shifter on the accept edge. All ops go straight to DONE with latency 1, the SHIFT state and cnt are not built, and busy is constant 0. flag_c equals the last bit shifted out (bit n-1 for right shifts, bit WIDTH-n for left shifts), and is 0 when n=0.
- Undefined: iterative behaviour as specified above.
- Results and flags are identical in both builds; only latency differs.

Decomposition:
- Shared package kgp_alu_pkg holds:
  - the alu_op encoding constants;
  - the FSM state typedef (IDLE, SHIFT, DONE);
  - WIDTH and SHAMT_W defaults.
- One combinational sub-module, alu_flag_gen, computes Z, S and V from A, B, result and op. It is reused by writeback/branch logic.

Test Plan:
- ADD A=0x7FFFFFFF, B=0x00000001 -> done one cycle after accept; result=0x80000000, V=1, S=1, C=0, Z=0.
- ADD A=0xFFFFFFFF, B=0x00000001 -> result=0, C=1, Z=1, V=0. COMP B=5 -> result=0xFFFFFFFB, S=1.
- SHRA A=0x80000010, n=4 -> busy for 4 cycles, done at accept+5; result=0xF8000001, C=0. SHRL by the same n=4 -> 0x08000001.
- SHLL A=0x80000001, n=1 -> result=0x00000002, C=1. SHLL with n=0 -> result=A, latency 1, C=0.
- start pulsed with ADD during a SHRL n=8 -> ignored; shift result is unchanged; alu_op=9 -> illegal=1, result=0.
- rst asserted at cycle 3 of SHLL n=10 -> next cycle: IDLE, ready=1, result=0, no done pulse; a fresh ADD afterwards completes normally.

Source files
------------

// File: rtl/kgp_alu_pkg.sv
// Shared ALU definitions: op encodings, execute FSM states, datapath defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package kgp_alu_pkg;

   localparam int WIDTH_DEF   = 32;
   localparam int SHAMT_W_DEF = 5;

   // Decoded ALU op encodings; 7..15 are unused and flagged as illegal.
   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_COMP = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_XOR  = 4'd3;
   localparam logic [3:0] OP_SHLL = 4'd4;
   localparam logic [3:0] OP_SHRL = 4'd5;
   localparam logic [3:0] OP_SHRA = 4'd6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } alu_state_t;

   function automatic logic is_shift_op(input logic [3:0] op);
      return (op == OP_SHLL) || (op == OP_SHRL) || (op == OP_SHRA);
   endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Zero / sign / signed-overflow flag generator shared with writeback and branch logic.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module alu_flag_gen
   import kgp_alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             a_sign,
   input  logic             b_sign,
   input  logic [WIDTH-1:0] res,
   input  logic [3:0]       op,
   output logic             z,
   output logic             s,
   output logic             v
);

   assign z = (res == '0);
   assign s = res[WIDTH-1];
   // Overflow only exists for ADD: like-signed operands producing an opposite-signed sum.
   assign v = (op == OP_ADD) && (a_sign == b_sign) && (res[WIDTH-1] != a_sign);

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute unit: single-cycle logic/arith ops, one-bit-per-cycle shifts (macro SEQ_ALU_BARREL_EN makes shifts single-cycle).
// Latency: 1 cycle for non-shift ops and zero-length shifts, n+1 cycles for a shift by n>0.
// Backpressure: start is taken only while ready=1; a start during busy is dropped, not queued.
module seq_alu
   import kgp_alu_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int SHAMT_W = SHAMT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] inp1,
   input  logic [WIDTH-1:0] inp2,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             flag_c,
   output logic             flag_z,
   output logic             flag_s,
   output logic             flag_v,
   output logic             illegal
);

   alu_state_t state;

   logic [SHAMT_W-1:0] n;
   logic [WIDTH-1:0]   cr;
   logic               cc;
   logic               cill;

   logic               fa_sign;
   logic               fb_sign;
   logic [WIDTH-1:0]   fres;
   logic [3:0]         fop;
   logic               fz;
   logic               fs;
   logic               fv;

   assign n = inp2[SHAMT_W-1:0];

`ifndef SEQ_ALU_BARREL_EN
   localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

   logic [WIDTH-1:0]   acc;
   logic [SHAMT_W-1:0] cnt;
   logic [3:0]         op_q;
   logic               cshift_iter;
   logic [WIDTH-1:0]   step_acc;
   logic               step_c;
   logic               in_shift;
`endif

   // Result and carry of the op presented on the inputs, as committed on an accept edge.
   always_comb begin
      cr   = '0;
      cc   = 1'b0;
      cill = 1'b0;
`ifndef SEQ_ALU_BARREL_EN
      cshift_iter = 1'b0;
`endif
      case (alu_op)
         OP_ADD:  {cc, cr} = {1'b0, inp1} + {1'b0, inp2};
         OP_COMP: cr = '0 - inp2;
         OP_AND:  cr = inp1 & inp2;
         OP_XOR:  cr = inp1 ^ inp2;
         OP_SHLL, OP_SHRL, OP_SHRA: begin
`ifdef SEQ_ALU_BARREL_EN
            // The extra bit beside the operand catches the last bit shifted out; it stays 0 for n=0.
            if (alu_op == OP_SHLL) begin
               {cc, cr} = {1'b0, inp1} << n;
            end else if (alu_op == OP_SHRL) begin
               {cr, cc} = {inp1, 1'b0} >> n;
            end else begin
               {cr, cc} = $signed({inp1, 1'b0}) >>> n;
            end
`else
            if (n == '0) begin
               cr = inp1;
            end else begin
               cshift_iter = 1'b1;
            end
`endif
         end
         default: cill = 1'b1;
      endcase
   end

`ifndef SEQ_ALU_BARREL_EN
   // One-bit shift step of the accumulator with the bit that falls off the end.
   always_comb begin
      step_acc = acc;
      step_c   = 1'b0;
      case (op_q)
         OP_SHLL: {step_c, step_acc} = {acc, 1'b0};
         OP_SHRL: {step_acc, step_c} = {1'b0, acc};
         default: {step_acc, step_c} = {acc[WIDTH-1], acc};
      endcase
   end

   assign in_shift = (state == ST_SHIFT);
   assign fa_sign  = in_shift ? acc[WIDTH-1] : inp1[WIDTH-1];
   assign fb_sign  = in_shift ? 1'b0         : inp2[WIDTH-1];
   assign fres     = in_shift ? step_acc     : cr;
   assign fop      = in_shift ? op_q         : alu_op;
`else
   assign fa_sign = inp1[WIDTH-1];
   assign fb_sign = inp2[WIDTH-1];
   assign fres    = cr;
   assign fop     = alu_op;
`endif

   alu_flag_gen #(
      .WIDTH (WIDTH)
   ) u_flag_gen (
      .a_sign (fa_sign),
      .b_sign (fb_sign),
      .res    (fres),
      .op     (fop),
      .z      (fz),
      .s      (fs),
      .v      (fv)
   );

   // Execute FSM: accepts ops, steps shifts, and commits result/flags together with done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         result  <= '0;
         flag_c  <= 1'b0;
         flag_z  <= 1'b0;
         flag_s  <= 1'b0;
         flag_v  <= 1'b0;
         done    <= 1'b0;
         illegal <= 1'b0;
         busy    <= 1'b0;
         ready   <= 1'b1;
`ifndef SEQ_ALU_BARREL_EN
         acc     <= '0;
         cnt     <= '0;
         op_q    <= '0;
`endif
      end else begin
         done    <= 1'b0;
         illegal <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
`ifndef SEQ_ALU_BARREL_EN
                  if (cshift_iter) begin
                     acc   <= inp1;
                     cnt   <= n;
                     op_q  <= alu_op;
                     state <= ST_SHIFT;
                     busy  <= 1'b1;
                     ready <= 1'b0;
                  end else
`endif
                  begin
                     result  <= cr;
                     flag_c  <= cc;
                     flag_z  <= fz;
                     flag_s  <= fs;
                     flag_v  <= fv;
                     illegal <= cill;
                     done    <= 1'b1;
                     state   <= ST_DONE;
                     busy    <= 1'b0;
                     ready   <= 1'b1;
                  end
               end else begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  ready <= 1'b1;
               end
            end
`ifndef SEQ_ALU_BARREL_EN
            ST_SHIFT: begin
               acc <= step_acc;
               cnt <= cnt - CNT_ONE;
               // Last step: publish the final value; intermediate steps never reach result.
               if (cnt == CNT_ONE) begin
                  result <= step_acc;
                  flag_c <= step_c;
                  flag_z <= fz;
                  flag_s <= fs;
                  flag_v <= fv;
                  done   <= 1'b1;
                  state  <= ST_DONE;
                  busy   <= 1'b0;
                  ready  <= 1'b1;
               end
            end
`endif
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
